// File: rtl/bg_pkg.sv
// Shared constants, FSM state type and address helper for the background restorer.
package bg_pkg;
    localparam int SCREEN_W = 320;
    localparam int SCREEN_H = 240;
    localparam int COLOR_W  = 9;
    localparam int ADDR_W   = 17;

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    // y*320 + x without a multiplier: 320 = 256 + 64
    function automatic logic [ADDR_W-1:0] pix_addr(input logic [8:0] x, input logic [7:0] y);
        logic [ADDR_W-1:0] yy;
        yy = {9'd0, y};
        return (yy << 8) + (yy << 6) + {8'd0, x};
    endfunction
endpackage

// File: rtl/bg_scan_counter.sv
// Bounded raster counter: walks (xs..xe, ys..ye) one step per cycle, holds on the last pixel.
module bg_scan_counter (
    input  logic       clock,
    input  logic       reset,
    input  logic       load,
    input  logic       step,
    input  logic [8:0] xs,
    input  logic [8:0] xe,
    input  logic [7:0] ys,
    input  logic [7:0] ye,
    output logic [8:0] cx,
    output logic [7:0] cy,
    output logic       last
);
    logic [8:0] xs_r, xe_r;
    logic [7:0] ye_r;

    assign last = (cx == xe_r) && (cy == ye_r);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cx   <= '0;
            cy   <= '0;
            xs_r <= '0;
            xe_r <= '0;
            ye_r <= '0;
        end else if (load) begin
            cx   <= xs;
            cy   <= ys;
            xs_r <= xs;
            xe_r <= xe;
            ye_r <= ye;
        end else if (step && !last) begin
            if (cx == xe_r) begin
                cx <= xs_r;
                cy <= cy + 8'd1;
            end else begin
                cx <= cx + 9'd1;
            end
        end
    end
endmodule

// File: rtl/background_restorer.sv
// Copies a full screen or clipped rectangle from the background ROM to the VGA plot port,
// hiding the ROM's one-cycle read latency behind a one-stage pipeline.
module background_restorer
    import bg_pkg::*;
#(
    parameter int SCREEN_W = bg_pkg::SCREEN_W,
    parameter int SCREEN_H = bg_pkg::SCREEN_H,
    parameter int COLOR_W  = bg_pkg::COLOR_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               full,
    input  logic [8:0]         rect_x0,
    input  logic [7:0]         rect_y0,
    input  logic [8:0]         rect_w,
    input  logic [7:0]         rect_h,
    input  logic               pause,
    output logic [ADDR_W-1:0]  rom_address,
    input  logic [COLOR_W-1:0] rom_q,
    output logic [8:0]         vga_x,
    output logic [7:0]         vga_y,
    output logic [COLOR_W-1:0] vga_colour,
    output logic               vga_plot,
    output logic               busy,
    output logic               done
);
    localparam logic [9:0] XLAST = 10'(SCREEN_W - 1);
    localparam logic [9:0] YLAST = 10'(SCREEN_H - 1);

    state_t     state, state_n;
    logic       load, issue, last, empty;
    logic [9:0] xe_sum, ye_sum;
    logic [8:0] xs, xe, cx, px;
    logic [7:0] ys, ye, cy, py;
    logic       pv;

    // 10-bit sums so a rectangle hanging off the right/bottom edge clips instead of wrapping
    always_comb begin
        xe_sum = {1'b0, rect_x0} + {1'b0, rect_w} - 10'd1;
        ye_sum = {2'b0, rect_y0} + {2'b0, rect_h} - 10'd1;
        empty  = !full && (rect_w == '0 || rect_h == '0 ||
                           {1'b0, rect_x0} > XLAST || {2'b0, rect_y0} > YLAST);
        if (full) begin
            xs = '0;
            ys = '0;
            xe = XLAST[8:0];
            ye = YLAST[7:0];
        end else begin
            xs = rect_x0;
            ys = rect_y0;
            xe = (xe_sum > XLAST) ? XLAST[8:0] : xe_sum[8:0];
            ye = (ye_sum > YLAST) ? YLAST[7:0] : ye_sum[7:0];
        end
    end

    bg_scan_counter u_cnt (
        .clock (clock),
        .reset (reset),
        .load  (load),
        .step  (issue),
        .xs    (xs),
        .xe    (xe),
        .ys    (ys),
        .ye    (ye),
        .cx    (cx),
        .cy    (cy),
        .last  (last)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= IDLE;
        else       state <= state_n;
    end

    always_comb begin
        state_n = state;
        load    = 1'b0;
        issue   = 1'b0;
        unique case (state)
            IDLE: if (start) begin
                load    = !empty;
                state_n = empty ? DONE : SCAN;
            end
            SCAN: if (!pause) begin
                issue = 1'b1;
                if (last) state_n = DRAIN;
            end
            DRAIN: if (!pause && pv) state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            px <= '0;
            py <= '0;
            pv <= 1'b0;
        end else if (issue) begin
            px <= cx;
            py <= cy;
            pv <= 1'b1;
        end else if (!pause) begin
            pv <= 1'b0;
        end
    end

    // While paused, keep re-reading the held pixel so rom_q is valid the cycle pause drops
    assign rom_address = pause ? pix_addr(px, py) : pix_addr(cx, cy);
    assign vga_x       = px;
    assign vga_y       = py;
    assign vga_colour  = rom_q;
    assign vga_plot    = pv && !pause;
    assign busy        = (state == SCAN) || (state == DRAIN);
    assign done        = (state == DONE);
endmodule

// File: tb/tb_background_restorer.sv
// Directed bench for background_restorer with a registered-read ROM model and plot logger.
module tb_background_restorer;
    logic        clock = 1'b0;
    logic        reset, start, full, pause;
    logic [8:0]  rect_x0, rect_w;
    logic [7:0]  rect_y0, rect_h;
    logic [16:0] rom_address;
    logic [8:0]  rom_q;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [8:0]  vga_colour;
    logic        vga_plot, busy, done;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int t0    = 0;
    int pause_viol = 0;
    int qx[$], qy[$], qc[$], qt[$];

    background_restorer dut (
        .clock(clock), .reset(reset), .start(start), .full(full),
        .rect_x0(rect_x0), .rect_y0(rect_y0), .rect_w(rect_w), .rect_h(rect_h),
        .pause(pause), .rom_address(rom_address), .rom_q(rom_q),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .vga_plot(vga_plot), .busy(busy), .done(done)
    );

    function automatic logic [8:0] romv(input logic [16:0] a);
        return a[8:0] ^ {1'b0, a[16:9]};
    endfunction

    function automatic logic [16:0] eaddr(input int x, input int y);
        return 17'(y * 320 + x);
    endfunction

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;
    always @(posedge clock) rom_q <= romv(rom_address);

    always @(negedge clock) begin
        if (vga_plot) begin
            qx.push_back(int'(vga_x));
            qy.push_back(int'(vga_y));
            qc.push_back(int'(vga_colour));
            qt.push_back(cyc - t0);
        end
        if (vga_plot && pause) pause_viol <= pause_viol + 1;
    end

    task automatic clear_log;
        qx.delete(); qy.delete(); qc.delete(); qt.delete();
    endtask

    task automatic launch(input logic f, input int x0, input int y0, input int w, input int h);
        @(posedge clock); #1;
        full = f; rect_x0 = 9'(x0); rect_y0 = 8'(y0); rect_w = 9'(w); rect_h = 8'(h);
        start = 1'b1;
        t0 = cyc;
        @(posedge clock); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output int at);
        at = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clock);
            if (done) begin
                at = cyc - t0;
                break;
            end
        end
    endtask

    task automatic test_reset;
        #13;
        total += 6;
        if (vga_plot !== 1'b0)     begin bad++; $display("FAIL reset_plot: got %b expected 0", vga_plot); end
        if (busy !== 1'b0)         begin bad++; $display("FAIL reset_busy: got %b expected 0", busy); end
        if (done !== 1'b0)         begin bad++; $display("FAIL reset_done: got %b expected 0", done); end
        if (rom_address !== 17'd0) begin bad++; $display("FAIL reset_addr: got %0d expected 0", rom_address); end
        if (vga_x !== 9'd0)        begin bad++; $display("FAIL reset_x: got %0d expected 0", vga_x); end
        if (vga_y !== 8'd0)        begin bad++; $display("FAIL reset_y: got %0d expected 0", vga_y); end
        @(negedge clock);
        reset = 1'b0;
    endtask

    task automatic test_rect;
        int ea[4] = '{1610, 1611, 1930, 1931};
        int ex[4] = '{10, 11, 10, 11};
        int ey[4] = '{5, 5, 6, 6};
        int a[4];
        int at;
        clear_log();
        launch(1'b0, 10, 5, 2, 2);
        for (int k = 0; k < 4; k++) begin
            @(negedge clock);
            a[k] = int'(rom_address);
            if (k == 0) begin
                total++;
                if (busy !== 1'b1) begin bad++; $display("FAIL rect_busy1: got %b expected 1", busy); end
            end
        end
        wait_done(20, at);
        for (int k = 0; k < 4; k++) begin
            total++;
            if (a[k] != ea[k]) begin bad++; $display("FAIL rect_addr%0d: got %0d expected %0d", k, a[k], ea[k]); end
        end
        total++;
        if (qx.size() != 4) begin bad++; $display("FAIL rect_count: got %0d expected 4", qx.size()); end
        for (int k = 0; k < 4 && k < qx.size(); k++) begin
            total++;
            if (qx[k] != ex[k] || qy[k] != ey[k] || qc[k] != int'(romv(eaddr(ex[k], ey[k]))) || qt[k] != k + 2) begin
                bad++;
                $display("FAIL rect_plot%0d: got (%0d,%0d) c=%0d t=%0d expected (%0d,%0d) c=%0d t=%0d",
                         k, qx[k], qy[k], qc[k], qt[k], ex[k], ey[k], romv(eaddr(ex[k], ey[k])), k + 2);
            end
        end
        total++;
        if (at != 6) begin bad++; $display("FAIL rect_done: got cycle %0d expected 6", at); end
        @(negedge clock);
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin bad++; $display("FAIL rect_idle: got busy=%b done=%b expected 0 0", busy, done); end
    endtask

    task automatic test_clip;
        int ex[4] = '{318, 319, 318, 319};
        int ey[4] = '{238, 238, 239, 239};
        int at;
        clear_log();
        launch(1'b0, 318, 238, 4, 4);
        wait_done(20, at);
        total++;
        if (qx.size() != 4) begin bad++; $display("FAIL clip_count: got %0d expected 4", qx.size()); end
        for (int k = 0; k < 4 && k < qx.size(); k++) begin
            total++;
            if (qx[k] != ex[k] || qy[k] != ey[k] || qc[k] != int'(romv(eaddr(ex[k], ey[k])))) begin
                bad++;
                $display("FAIL clip_plot%0d: got (%0d,%0d) c=%0d expected (%0d,%0d) c=%0d",
                         k, qx[k], qy[k], qc[k], ex[k], ey[k], romv(eaddr(ex[k], ey[k])));
            end
        end
        total++;
        if (at != 6) begin bad++; $display("FAIL clip_done: got cycle %0d expected 6", at); end
    endtask

    task automatic test_empty;
        int xs[3] = '{5, 320, 7};
        int ws[3] = '{0, 3, 3};
        int hs[3] = '{3, 3, 0};
        for (int j = 0; j < 3; j++) begin
            clear_log();
            launch(1'b0, xs[j], 5, ws[j], hs[j]);
            @(negedge clock);
            total++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                bad++; $display("FAIL empty%0d_c1: got done=%b busy=%b expected 1 0", j, done, busy);
            end
            repeat (4) @(negedge clock);
            total++;
            if (qx.size() != 0 || done !== 1'b0) begin
                bad++; $display("FAIL empty%0d_plots: got %0d plots done=%b expected 0 0", j, qx.size(), done);
            end
        end
    endtask

    task automatic test_pause;
        logic [16:1] pat = 16'b0100_0011_1000_1101;
        int np, at, viol0;
        viol0 = pause_viol;
        np = $countones(pat);
        clear_log();
        launch(1'b0, 100, 50, 4, 4);
        for (int k = 1; k <= 16; k++) begin
            pause = pat[k];
            if (k < 16) begin @(posedge clock); #1; end
        end
        @(posedge clock); #1;
        pause = 1'b0;
        wait_done(60, at);
        total++;
        if (pause_viol != viol0) begin bad++; $display("FAIL pause_plot: got %0d plots under pause expected 0", pause_viol - viol0); end
        total++;
        if (qx.size() != 16) begin bad++; $display("FAIL pause_count: got %0d expected 16", qx.size()); end
        for (int k = 0; k < 16 && k < qx.size(); k++) begin
            total++;
            if (qx[k] != 100 + k % 4 || qy[k] != 50 + k / 4 || qc[k] != int'(romv(eaddr(100 + k % 4, 50 + k / 4)))) begin
                bad++;
                $display("FAIL pause_plot%0d: got (%0d,%0d) c=%0d expected (%0d,%0d)", k, qx[k], qy[k], qc[k], 100 + k % 4, 50 + k / 4);
            end
        end
        total++;
        if (at != 18 + np) begin bad++; $display("FAIL pause_done: got cycle %0d expected %0d", at, 18 + np); end
    endtask

    task automatic test_back_to_back;
        int at;
        clear_log();
        launch(1'b0, 20, 30, 2, 2);
        @(posedge clock); #1;
        full = 1'b1; start = 1'b1;
        @(posedge clock); #1;
        start = 1'b0; full = 1'b0;
        wait_done(20, at);
        total += 2;
        if (qx.size() != 4) begin bad++; $display("FAIL busy_ignore_count: got %0d expected 4", qx.size()); end
        if (at != 6)        begin bad++; $display("FAIL busy_ignore_done: got cycle %0d expected 6", at); end
        clear_log();
        launch(1'b0, 0, 0, 3, 1);
        wait_done(20, at);
        total += 2;
        if (at != 5) begin bad++; $display("FAIL restart_done: got cycle %0d expected 5", at); end
        if (qx.size() != 3 || qx[0] != 0 || qx[2] != 2 || qy[2] != 0) begin
            bad++; $display("FAIL restart_plots: got %0d plots expected 3 at (0..2,0)", qx.size());
        end
    endtask

    task automatic test_reset_mid;
        int at;
        clear_log();
        launch(1'b1, 0, 0, 0, 0);
        repeat (10) @(posedge clock);
        #3;
        total++;
        if (vga_plot !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL midreset_pre: got plot=%b busy=%b expected 1 1", vga_plot, busy); end
        reset = 1'b1;
        #1;
        total++;
        if ({vga_plot, busy, done} !== 3'b000 || rom_address !== 17'd0 || vga_x !== 9'd0 || vga_y !== 8'd0) begin
            bad++;
            $display("FAIL midreset_outs: got plot=%b busy=%b done=%b addr=%0d x=%0d y=%0d expected all 0",
                     vga_plot, busy, done, rom_address, vga_x, vga_y);
        end
        @(negedge clock);
        reset = 1'b0;
        clear_log();
        launch(1'b0, 1, 1, 2, 2);
        wait_done(20, at);
        total++;
        if (at != 6 || qx.size() != 4 || qx[0] != 1 || qy[0] != 1 || qx[3] != 2 || qy[3] != 2) begin
            bad++; $display("FAIL midreset_fresh: got done=%0d plots=%0d expected done=6 plots=4 (1,1)..(2,2)", at, qx.size());
        end
    endtask

    task automatic test_full;
        int at, errs, la;
        clear_log();
        la = -1;
        at = -1;
        launch(1'b1, 0, 0, 0, 0);
        for (int i = 0; i < 77000; i++) begin
            @(negedge clock);
            if (cyc - t0 == 76800) la = int'(rom_address);
            if (done) begin at = cyc - t0; break; end
        end
        errs = 0;
        for (int i = 0; i < qx.size(); i++)
            if (qx[i] != i % 320 || qy[i] != i / 320 || qc[i] != int'(romv(eaddr(i % 320, i / 320))) || qt[i] != i + 2)
                errs++;
        total += 5;
        if (qx.size() != 76800) begin bad++; $display("FAIL full_count: got %0d expected 76800", qx.size()); end
        if (errs != 0)          begin bad++; $display("FAIL full_order: got %0d wrong plots expected 0", errs); end
        if (qx.size() == 0 || qx[qx.size()-1] != 319 || qy[qy.size()-1] != 239) begin
            bad++; $display("FAIL full_last: got %0d plots, last not (319,239)", qx.size());
        end
        if (la != 76799) begin bad++; $display("FAIL full_lastaddr: got %0d expected 76799", la); end
        if (at != 76802) begin bad++; $display("FAIL full_done: got cycle %0d expected 76802", at); end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; full = 1'b0; pause = 1'b0;
        rect_x0 = '0; rect_y0 = '0; rect_w = '0; rect_h = '0;
        test_reset();
        test_rect();
        test_clip();
        test_empty();
        test_pause();
        test_back_to_back();
        test_reset_mid();
        test_full();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
